plab4_net_tdm_domain_sched: RTL and testbench

Time-division domain scheduler for the two-domain timing-protected ring router. It produces the public-label `domain` select that steers the per-router input-control arbiter between the D0 and D1 input controllers, and an injection-enable that closes each slot with a drain window. The schedule is fixed and demand-independent, so one domain's traffic cannot change when the other domain's slot starts. One instance sits per router, and all instances are released by a common `en`.

---
 rtl/plab4_net_tdm_domain_sched.sv | 125 ++++++++++++
 tb/tb_plab4_net_tdm_domain_sched.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/plab4_net_tdm_domain_sched.sv
// Time-division domain scheduler for the two-domain ring router.
// Emits a fixed, demand-independent schedule: each slot of p_slot_len cycles
// belongs to one domain, opens with an injection window and closes with a
// p_dead_len-cycle drain window. The block has no data inputs, so traffic in
// either domain cannot move a slot boundary.
module plab4_net_tdm_domain_sched #(
   parameter int p_slot_len  = 16,
   parameter int p_dead_len  = 3,
   parameter int c_cnt_nbits = (p_slot_len > 1) ? $clog2(p_slot_len) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en,
   output logic                   domain,
   output logic                   inj_en,
   output logic                   slot_start,
   output logic [c_cnt_nbits-1:0] slot_cnt
);

   // Reject schedules that cannot hold an injection cycle plus a drain cycle.
   if ((p_slot_len < 2) || (p_dead_len < 1) || (p_dead_len >= p_slot_len)) begin : g_param_err
      $error("plab4_net_tdm_domain_sched: need p_slot_len >= 2 and 1 <= p_dead_len < p_slot_len");
   end

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACTIVE = 2'd1,
      S_DRAIN  = 2'd2
   } state_e;

   // Last injection cycle and last cycle of a slot, as counter values.
   localparam logic [c_cnt_nbits-1:0] c_last_act = c_cnt_nbits'(p_slot_len - p_dead_len - 1);
   localparam logic [c_cnt_nbits-1:0] c_last_cnt = c_cnt_nbits'(p_slot_len - 1);
   localparam logic [c_cnt_nbits-1:0] c_one      = c_cnt_nbits'(1);

   state_e                   state_q,      state_d;
   logic                     domain_q,     domain_d;
   logic                     inj_en_q,     inj_en_d;
   logic                     slot_start_q, slot_start_d;
   logic [c_cnt_nbits-1:0]   slot_cnt_q,   slot_cnt_d;

   // State and registered outputs; synchronous reset returns to IDLE defaults.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge value of every other flop.
      if (reset) begin
         state_q      <= S_IDLE;
         domain_q     <= 1'b0;
         inj_en_q     <= 1'b0;
         slot_start_q <= 1'b0;
         slot_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         domain_q     <= domain_d;
         inj_en_q     <= inj_en_d;
         slot_start_q <= slot_start_d;
         slot_cnt_q   <= slot_cnt_d;
      end
   end

   // Next-state and next-output logic; en is only looked at in IDLE and on
   // the last drain cycle, so a slot in progress always runs to completion.
   always_comb begin
      // NOTE: every signal written here gets a default first so no path
      // leaves one unassigned and infers a latch.
      state_d      = state_q;
      domain_d     = domain_q;
      inj_en_d     = inj_en_q;
      slot_start_d = 1'b0;
      slot_cnt_d   = slot_cnt_q;

      case (state_q)
         S_IDLE: begin
            domain_d   = 1'b0;
            inj_en_d   = 1'b0;
            slot_cnt_d = '0;
            if (en) begin
               state_d      = S_ACTIVE;
               slot_start_d = 1'b1;
               inj_en_d     = 1'b1;
            end
         end

         S_ACTIVE: begin
            inj_en_d   = 1'b1;
            slot_cnt_d = slot_cnt_q + c_one;
            if (slot_cnt_q == c_last_act) begin
               state_d  = S_DRAIN;
               inj_en_d = 1'b0;
            end
         end

         S_DRAIN: begin
            inj_en_d = 1'b0;
            if (slot_cnt_q == c_last_cnt) begin
               slot_cnt_d = '0;
               if (en) begin
                  state_d      = S_ACTIVE;
                  domain_d     = ~domain_q;
                  slot_start_d = 1'b1;
                  inj_en_d     = 1'b1;
               end else begin
                  state_d  = S_IDLE;
                  domain_d = 1'b0;
               end
            end else begin
               slot_cnt_d = slot_cnt_q + c_one;
            end
         end

         default: begin
            state_d    = S_IDLE;
            domain_d   = 1'b0;
            inj_en_d   = 1'b0;
            slot_cnt_d = '0;
         end
      endcase
   end

   assign domain     = domain_q;
   assign inj_en     = inj_en_q;
   assign slot_start = slot_start_q;
   assign slot_cnt   = slot_cnt_q;

endmodule

// File: tb/tb_plab4_net_tdm_domain_sched.sv
// Bench for plab4_net_tdm_domain_sched: three instances (8/2, 4/3, 16/3)
// share reset and en and are compared every cycle against a slot-position
// model (running flag, cycle within slot, slot number).
module tb_plab4_net_tdm_domain_sched;

   logic clk = 1'b0;
   logic reset;
   logic en;

   logic       dom_a, inj_a, st_a;
   logic [2:0] cnt_a;
   logic       dom_b, inj_b, st_b;
   logic [1:0] cnt_b;
   logic       dom_c, inj_c, st_c;
   logic [3:0] cnt_c;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit run;
      int cyc;
      int slot;
   } mdl_t;

   mdl_t m_a, m_b, m_c;

   always #5 clk = ~clk;

   plab4_net_tdm_domain_sched #(.p_slot_len(8), .p_dead_len(2)) u_dut_a (
      .clk(clk), .reset(reset), .en(en),
      .domain(dom_a), .inj_en(inj_a), .slot_start(st_a), .slot_cnt(cnt_a)
   );

   plab4_net_tdm_domain_sched #(.p_slot_len(4), .p_dead_len(3)) u_dut_b (
      .clk(clk), .reset(reset), .en(en),
      .domain(dom_b), .inj_en(inj_b), .slot_start(st_b), .slot_cnt(cnt_b)
   );

   plab4_net_tdm_domain_sched u_dut_c (
      .clk(clk), .reset(reset), .en(en),
      .domain(dom_c), .inj_en(inj_c), .slot_start(st_c), .slot_cnt(cnt_c)
   );

   task automatic check(input string tag, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   // Slot-position model: a slot is just a count of cycles since it began.
   function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit e, input int s_len);
      mdl_t n = m;
      if (r) begin
         n.run = 1'b0; n.cyc = 0; n.slot = 0;
      end else if (!m.run) begin
         if (e) begin
            n.run = 1'b1; n.cyc = 0; n.slot = 0;
         end
      end else if (m.cyc == s_len - 1) begin
         if (e) begin
            n.cyc = 0; n.slot = m.slot + 1;
         end else begin
            n.run = 1'b0; n.cyc = 0; n.slot = 0;
         end
      end else begin
         n.cyc = m.cyc + 1;
      end
      return n;
   endfunction

   task automatic check_inst(input string name, input int cyc_no, input mdl_t m,
                             input int s_len, input int d_len,
                             input int dom, input int inj, input int st, input int cnt);
      int e_dom, e_inj, e_st, e_cnt;
      e_dom = m.run ? (m.slot % 2) : 0;
      e_inj = (m.run && (m.cyc < s_len - d_len)) ? 1 : 0;
      e_st  = (m.run && (m.cyc == 0)) ? 1 : 0;
      e_cnt = m.run ? m.cyc : 0;
      check($sformatf("%s_domain@%0d", name, cyc_no), dom, e_dom);
      check($sformatf("%s_inj_en@%0d", name, cyc_no), inj, e_inj);
      check($sformatf("%s_slot_start@%0d", name, cyc_no), st, e_st);
      check($sformatf("%s_slot_cnt@%0d", name, cyc_no), cnt, e_cnt);
   endtask

   int cyc_no = 0;

   // One clock: apply inputs, advance models on the edge, compare 1 time unit later.
   task automatic run_cycle(input bit r, input bit e);
      reset = r;
      en    = e;
      @(posedge clk);
      m_a = mdl_step(m_a, r, e, 8);
      m_b = mdl_step(m_b, r, e, 4);
      m_c = mdl_step(m_c, r, e, 16);
      #1;
      cyc_no++;
      check_inst("a8_2", cyc_no, m_a, 8, 2, int'(dom_a), int'(inj_a), int'(st_a), int'(cnt_a));
      check_inst("b4_3", cyc_no, m_b, 4, 3, int'(dom_b), int'(inj_b), int'(st_b), int'(cnt_b));
      check_inst("c16_3", cyc_no, m_c, 16, 3, int'(dom_c), int'(inj_c), int'(st_c), int'(cnt_c));
   endtask

   initial begin
      bit e_rand;
      m_a = '{run: 1'b0, cyc: 0, slot: 0};
      m_b = m_a;
      m_c = m_a;
      reset = 1'b1;
      en    = 1'b0;

      // Reset values, then idle with en low: no implicit start.
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
      for (int i = 0; i < 10; i++) run_cycle(1'b0, 1'b0);

      // Basic schedule: en is raised in cycle k=0 and held.
      for (int k = 0; k < 20; k++) begin
         run_cycle(1'b0, 1'b1);
         if (k + 1 == 1)  check("basic_first_start", int'(st_a), 1);
         if (k + 1 == 7)  check("basic_drain_c7", int'(inj_a), 0);
         if (k + 1 == 6)  check("basic_inj_c6", int'(inj_a), 1);
         if (k + 1 == 9)  check("basic_d1_start", int'({dom_a, st_a}), 3);
         if (k + 1 == 17) check("basic_d0_restart", int'({dom_a, st_a}), 1);
      end

      // Stop at slot boundary: drop en at slot_cnt 2 of a D1 slot (bounded search).
      for (int k = 0; k < 40; k++) begin
         if (m_a.run && (m_a.slot % 2 == 1) && (m_a.cyc == 2)) break;
         run_cycle(1'b0, 1'b1);
      end
      check("stop_found_d1_cnt2", int'(cnt_a), 2);
      for (int k = 0; k < 5; k++) run_cycle(1'b0, 1'b0);
      check("stop_slot_completes", int'(cnt_a), 7);
      for (int k = 0; k < 12; k++) run_cycle(1'b0, 1'b0);
      check("stop_idle_domain", int'({dom_a, inj_a, st_a}), 0);
      run_cycle(1'b0, 1'b1);
      check("restart_d0", int'({dom_a, st_a}), 1);

      // Reset mid-slot at slot_cnt 5 of D1 with en held high.
      for (int k = 0; k < 40; k++) begin
         if (m_a.run && (m_a.slot % 2 == 1) && (m_a.cyc == 5)) break;
         run_cycle(1'b0, 1'b1);
      end
      check("rst_found_d1_cnt5", int'(cnt_a), 5);
      run_cycle(1'b1, 1'b1);
      check("rst_mid_slot_idle", int'({dom_a, inj_a, st_a, cnt_a}), 0);
      run_cycle(1'b0, 1'b1);
      check("rst_fresh_d0", int'({dom_a, inj_a, st_a}), 3);

      // Randomized: en mostly steady with occasional toggles, rare resets.
      e_rand = 1'b1;
      for (int k = 0; k < 1500; k++) begin
         if ($urandom_range(0, 11) == 0) e_rand = ~e_rand;
         run_cycle(($urandom_range(0, 149) == 0), e_rand);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
